inv_pipe: RTL
=============

# inv_pipe

Parametrised, multi-stage, elastic inverting datapath for the AES core. Each accepted word is XORed with a runtime-programmable polarity mask, then carried through DEPTH registered stages with valid/ready backpressure. It replaces hand-placed inverter cells on wide state buses, such as the 128-bit round-state path, wherever a registered and selectively inverted copy is needed. Throughput is one word per cycle.

## Interface

Parameters:
- WIDTH, 128, data and mask width in bits (≥1)
- DEPTH, 2, number of register stages (≥1; elaboration error if 0)
- INIT_MASK, all-ones, mask value after reset (all-ones gives a pure registered inverter)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mask_we  in  1  load mask_din into the mask register this cycle
- mask_din  in  WIDTH  new polarity mask (1 = invert bit)
- mask_q  out  WIDTH  current mask register
- in_valid  in  1  upstream word present
- in_ready  out  1  block accepts the word this cycle
- in_data  in  WIDTH  upstream word
- out_valid  out  1  word available at the tail stage
- out_ready  in  1  downstream accepts the word this cycle
- out_data  out  WIDTH  tail-stage word
- busy  out  1  OR of all stage valids

## Operation

- Accept: in_valid & in_ready. The stage-0 register captures in_data ^ mask_q, using the mask value present before any same-cycle mask_we.
- Stage i holds {v[i], d[i]}. Stage i advances when it is empty, or when stage i+1 advances or is empty. The tail advances on out_ready.
- in_ready = ~v[0] | adv[0]. This is combinational from out_ready through the stage chain, with no registered skid.
- Full: all v[i] = 1 and out_ready = 0. Then in_ready = 0 and every stage holds its data unchanged.
- Bubbles collapse: an empty stage always accepts from the stage before it.
- mask_we: mask_q <= mask_din on the clock edge. The new mask applies to words accepted from the next cycle. Words already in flight are never re-masked.
- Words are never dropped, duplicated or reordered.
- out_data = d[DEPTH-1]. It is undefined-free: out_data holds its last value while out_valid = 0.

## Timing

- Reset (asynchronous assert, synchronous release with clk) drives:
  - all v[i] = 0 and d[i] = 0
  - mask_q = INIT_MASK
  - out_valid = 0, out_data = 0, busy = 0
  - in_ready = 1 on the first cycle after release
- Reset mid-operation discards all in-flight words. No output pulse follows.
- Latency with an empty pipe and out_ready held high: a word accepted at edge n gives out_valid = 1 after edge n+DEPTH-1, and it is consumed at edge n+DEPTH.
- Sustained throughput is 1 word per cycle when out_ready = 1 continuously.
- A drain from full and a new accept in the same cycle is legal. Occupancy is then unchanged.
- Simultaneous mask_we and accept: the accepted word uses the old mask.
- in_data, mask_din and mask_we are sampled only on the clock edge. There are no combinational paths from in_data to out_data.

## Structure

- Package inv_pipe_pkg holds:
  - localparam AES_STATE_W = 128
  - typedef struct packed {logic v; logic [AES_STATE_W-1:0] d;} for the stage type
  - the default mask constant
- Sub-module inv_pipe_slot is one elastic register stage: in valid/data, next-stage ready, out valid/data, adv. It is instantiated DEPTH times in a generate loop.
- The top level holds the mask register, input XOR, in_ready and busy.

## Test plan

- Reset defaults, WIDTH=128, DEPTH=2: assert rst mid-stream with 2 words in flight. Required: out_valid=0, busy=0, mask_q=all-ones, and in_ready=1 after release.
- Pure inversion: in_data=0x0123…CDEF accepted at edge n, out_ready=1. Required: out_data=0xFEDC…3210 with out_valid=1 after edge n+1, and busy=0 after edge n+2.
- Mask change ordering: mask_we with mask_din=0x00FF… in the same cycle as accepting word A=0, then word B=0 on the next cycle. Required: A exits as all-ones and B exits as 0x00FF….
- Backpressure: out_ready=0, push 3 words. Required: the first 2 are accepted, then in_ready=0. Release out_ready. Required: the words exit in order, one per cycle, none lost.
- Stream at rate 1: 100 random words with random out_ready at 50%. Required: the scoreboard matches in_data^mask in order, and out_data is stable while out_valid & ~out_ready.
- DEPTH=1 and DEPTH=5 builds: a single word gives latency 1 and 5 cycles respectively. Simultaneous drain and accept at full keeps the occupancy constant.

Source files
------------

// File: rtl/inv_pipe_pkg.sv
// Shared definitions for the elastic inverting datapath.
// The stage type and default mask are sized for the AES round-state bus.
package inv_pipe_pkg;

  localparam int AES_STATE_W = 128;

  typedef struct packed {
    logic                   v;
    logic [AES_STATE_W-1:0] d;
  } stage_t;

  localparam logic [AES_STATE_W-1:0] DEFAULT_MASK = '1;

endpackage

// File: rtl/inv_pipe_slot.sv
// One elastic register stage: it loads whenever it is empty or its word moves on.
// Data is only overwritten by a valid word, so the register keeps its last word across bubbles.
module inv_pipe_slot
  import inv_pipe_pkg::*;
#(
  parameter int WIDTH = AES_STATE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             next_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             adv
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign adv   = ~valid_reg | next_ready;
  assign valid = valid_reg;
  assign data  = data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (adv) begin
      valid_reg <= prev_valid;
      if (prev_valid) begin
        data_reg <= prev_data;
      end
    end
  end

endmodule

// File: rtl/inv_pipe.sv
// Elastic, selectively inverting register pipeline: in_data ^ mask_q carried through DEPTH stages.
// in_ready ripples combinationally back from out_ready; there is no skid buffer.
module inv_pipe
  import inv_pipe_pkg::*;
#(
  parameter int               WIDTH     = AES_STATE_W,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] INIT_MASK = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_din,
  output logic [WIDTH-1:0] mask_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [WIDTH-1:0] mask_reg;
  logic [DEPTH-1:0] v_vec;

  // The head stage XORs with mask_reg before this edge's update, so a
  // same-cycle mask_we only affects the following words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg <= INIT_MASK;
    end else if (mask_we) begin
      mask_reg <= mask_din;
    end
  end

  assign mask_q = mask_reg;

  generate
    if (DEPTH < 1) begin : g_depth_check
      $error("inv_pipe: DEPTH must be at least 1");
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             prev_valid;
      logic [WIDTH-1:0] prev_data;
      logic             next_ready;
      logic             valid;
      logic [WIDTH-1:0] data;
      logic             adv;

      if (gi == 0) begin : g_head
        assign prev_valid = in_valid;
        assign prev_data  = in_data ^ mask_reg;
      end else begin : g_link
        assign prev_valid = g_stage[gi-1].valid;
        assign prev_data  = g_stage[gi-1].data;
      end

      if (gi == DEPTH - 1) begin : g_tail
        assign next_ready = out_ready;
      end else begin : g_mid
        assign next_ready = g_stage[gi+1].adv;
      end

      inv_pipe_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .prev_valid(prev_valid),
        .prev_data (prev_data),
        .next_ready(next_ready),
        .valid     (valid),
        .data      (data),
        .adv       (adv)
      );

      assign v_vec[gi] = valid;
    end
  endgenerate

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[DEPTH-1].valid;
  assign out_data  = g_stage[DEPTH-1].data;
  assign busy      = |v_vec;

endmodule
